// File: rtl/star_box_writer.sv
// Rasterises a star bounding box (outline or solid fill) into the 60x60 pixel RAM
// write port, one pixel per cycle, clipping the box to the image edges.
module star_box_writer #(
    parameter int unsigned X_SZ    = 6,
    parameter int unsigned Y_SZ    = 6,
    parameter int unsigned ADDR_SZ = 12,
    parameter int unsigned COL_SZ  = 3,
    parameter int unsigned X_RES   = 60,
    parameter int unsigned Y_RES   = 60
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [X_SZ-1:0]    left,
    input  logic [X_SZ-1:0]    right,
    input  logic [Y_SZ-1:0]    top,
    input  logic [Y_SZ-1:0]    bottom,
    input  logic [COL_SZ-1:0]  colour,
    input  logic               fill,
    output logic [ADDR_SZ-1:0] wr_addr,
    output logic [COL_SZ-1:0]  wr_data,
    output logic               wr_en,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [X_SZ-1:0] X_MAX = X_SZ'(X_RES - 1);
    localparam logic [Y_SZ-1:0] Y_MAX = Y_SZ'(Y_RES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, WRITE, FINISH} state_t;

    state_t              state, state_n;
    logic [X_SZ-1:0]     l_q, l_n, r_q, r_n, x_q, x_n;
    logic [Y_SZ-1:0]     t_q, t_n, b_q, b_n, y_q, y_n;
    logic [COL_SZ-1:0]   col_q, col_n;
    logic                fill_q, fill_n, errf_q, errf_n;
    logic [X_SZ-1:0]     r_clip;
    logic [Y_SZ-1:0]     b_clip;
    logic                interior_row;

    logic [ADDR_SZ-1:0]  wr_addr_n;
    logic [COL_SZ-1:0]   wr_data_n;
    logic                wr_en_n, busy_n, done_n, err_n;

    // Row-major address y*X_RES + x built from shifted copies of y.
    function automatic logic [ADDR_SZ-1:0] pix_addr(input logic [X_SZ-1:0] x,
                                                     input logic [Y_SZ-1:0] y);
        logic [ADDR_SZ-1:0] acc;
        acc = ADDR_SZ'(x);
        for (int i = 0; i < 32; i++) begin
            if (X_RES[i]) acc = acc + (ADDR_SZ'(y) << i);
        end
        return acc;
    endfunction

    assign r_clip       = (r_q > X_MAX) ? X_MAX : r_q;
    assign b_clip       = (b_q > Y_MAX) ? Y_MAX : b_q;
    assign interior_row = !fill_q && (y_q > t_q) && (y_q < b_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            t_q     <= '0;
            b_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            fill_q  <= 1'b0;
            errf_q  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_en   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_n;
            l_q     <= l_n;
            r_q     <= r_n;
            t_q     <= t_n;
            b_q     <= b_n;
            x_q     <= x_n;
            y_q     <= y_n;
            col_q   <= col_n;
            fill_q  <= fill_n;
            errf_q  <= errf_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            wr_en   <= wr_en_n;
            busy    <= busy_n;
            done    <= done_n;
            err     <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        l_n     = l_q;
        r_n     = r_q;
        t_n     = t_q;
        b_n     = b_q;
        x_n     = x_q;
        y_n     = y_q;
        col_n   = col_q;
        fill_n  = fill_q;
        errf_n  = errf_q;
        case (state)
            IDLE: begin
                if (start) begin
                    l_n     = left;
                    r_n     = right;
                    t_n     = top;
                    b_n     = bottom;
                    col_n   = colour;
                    fill_n  = fill;
                    errf_n  = 1'b0;
                    state_n = CHECK;
                end
            end
            CHECK: begin
                r_n = r_clip;
                b_n = b_clip;
                if ((l_q > r_clip) || (t_q > b_clip)) begin
                    errf_n  = 1'b1;
                    state_n = FINISH;
                end else begin
                    x_n     = l_q;
                    y_n     = t_q;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                // Outline rows strictly between top and bottom only touch left and right.
                if (x_q != r_q) begin
                    x_n = interior_row ? r_q : x_q + X_SZ'(1);
                end else if (y_q != b_q) begin
                    x_n = l_q;
                    y_n = y_q + Y_SZ'(1);
                end else begin
                    state_n = FINISH;
                end
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from next state and counters.
    always_comb begin
        wr_en_n   = (state_n == WRITE);
        wr_addr_n = '0;
        wr_data_n = '0;
        if (wr_en_n) begin
            wr_addr_n = pix_addr(x_n, y_n);
            wr_data_n = col_q;
        end
        busy_n = (state_n == CHECK) || (state_n == WRITE);
        done_n = (state_n == FINISH);
        err_n  = (state_n == FINISH) && errf_n;
    end

endmodule
